lsu_split: RTL
==============

Name: lsu_split

Overview:
- Load/store unit sitting directly upstream of the byte-addressed data memory.
- Accepts one load/store request at a time from the execute stage via a valid/ready handshake.
- Drives the memory's addr/data_in/load_code/store_code interface and returns the assembled, sign- or zero-extended load result as a one-cycle response.
- Aligned accesses take one memory beat; misaligned accesses are split into sequential byte beats.

Parameters:
ADDR_W, 32, width of request and memory address.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high when the request can be accepted (state IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, little-endian
resp_valid  out  1  one-cycle pulse, request complete
resp_rdata  out  32  extended load data (0 for stores and errors)
resp_err  out  1  qualified by resp_valid; illegal funct3 (or misaligned, see macro)
busy  out  1  high in any state other than IDLE
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  32  memory data_in
mem_load_code  out  3  memory load code; 3'b111 = idle
mem_store_code  out  2  memory store code; 2'b11 = idle
mem_rdata  in  32  memory data_out, combinational, valid in the same cycle as the load code

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - State IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - mem_addr=0, mem_wdata=0, mem_load_code=3'b111, mem_store_code=2'b11.
- FSM states: IDLE, BEAT, SPLIT, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch we/funct3/addr/wdata.
  - Legal funct3:
    - Loads: 000, 001, 010, 100, 101.
    - Stores: 000, 001, 010.
  - Illegal funct3 -> RESP with err=1; no memory beat is issued.
  - Aligned -> BEAT. Aligned means H with addr[0]=0, W with addr[1:0]=0, or any byte access.
  - Otherwise -> SPLIT with byte counter k=0.
- BEAT (1 cycle):
  - Drive mem_addr=addr and mem_wdata=wdata.
  - Code: funct3 passed through as mem_load_code for loads; mem_store_code=funct3[1:0] for stores. The unused code output holds its idle value.
  - Capture mem_rdata for loads. Next state RESP.
- SPLIT (N cycles, N = 2 for H/HU, 4 for W):
  - Beat k drives mem_addr = addr+k, mod 2^ADDR_W (wraps at the top of the address space).
  - Loads use mem_load_code=100 (LBU) and capture mem_rdata[7:0] into result byte k.
  - Stores use mem_store_code=00 (SB) with mem_wdata[7:0]=wdata[8k+7:8k].
  - After beat N-1 -> RESP.
- RESP (1 cycle):
  - resp_valid=1.
  - resp_rdata = assembled data extended per funct3: B/H sign-extend from bit 7/15; BU/HU zero-extend.
  - Stores and errors return 0.
  - Next state IDLE; req_ready goes high in the following cycle. There is no same-cycle accept in RESP.
- Latency from accept cycle T:
  - Aligned: resp_valid at T+2.
  - Split: resp_valid at T+N+1.
  - Error: resp_valid at T+1.
- Outside BEAT/SPLIT the memory codes hold idle values; mem_addr and mem_wdata hold their last values.
- req_valid is ignored while busy; the requester must hold it until accepted.
- Reset in any state:
  - Returns to IDLE with reset values; any in-flight request is dropped with no response.
  - Store bytes already written remain in memory.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned legal request goes IDLE -> RESP with resp_err=1 and resp_rdata=0. No memory beat is issued, so memory is unmodified. SPLIT is unreachable and may be omitted.
- Undefined: misaligned requests are split as described under Behaviour. resp_err is raised only for illegal funct3.

Test Plan:
- Aligned LW: mem bytes [0x10..0x13] = 11 22 33 44, LW addr 0x10 -> one beat with load_code 010; resp_valid at T+2, resp_rdata=0x44332211, err=0.
- Misaligned LH: bytes [0x03]=0x80, [0x04]=0xFF, LH addr 0x03 -> two LBU beats at 0x03 then 0x04; resp at T+3, rdata=0xFFFFFF80. LHU on the same address -> 0x0000FF80.
- Misaligned SW: SW 0xDEADBEEF at 0x01 -> four SB beats at 0x01..0x04 with data EF, BE, AD, DE; then LW at 0x01 returns 0xDEADBEEF; busy high for 5 cycles.
- Illegal funct3: load with funct3=011 -> resp_valid at T+1, err=1, rdata=0, no non-idle memory code. Store with funct3=100 -> same response.
- Reset mid-split: assert rst_n=0 during beat 1 of a misaligned SW at 0x05 -> next cycle req_ready=1, no resp_valid, byte 0x05 written, 0x07/0x08 unchanged.
- Macro on: LW at 0x02 -> resp at T+1 with err=1; memory unchanged. Macro off: the same access splits into 4 beats.

Source files
------------

// File: rtl/lsu_split.sv
// Load/store unit: aligned accesses take one memory beat, misaligned ones are split into byte beats.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned accesses with resp_err instead of splitting them.
module lsu_split #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [2:0]        mem_load_code,
   output logic [1:0]        mem_store_code,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, BEAT, SPLIT, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       data_q;
   logic              err_q;
   logic [1:0]        k;
   logic [1:0]        k_next;
   logic              legal;
   logic              misaligned;
   logic              last_beat;
   logic [ADDR_W-1:0] addr_plus;
   logic [31:0]       extended;

   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !req_we;
         default:                legal = 1'b0;
      endcase
   end

   assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
   assign last_beat  = (funct3_q[1:0] == 2'b10) ? (k == 2'd3) : (k == 2'd1);
   assign k_next     = k + 2'd1;
   assign addr_plus  = addr_q + ADDR_W'(k_next);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!legal)          state_next = RESP;
`ifdef LSU_MISALIGN_TRAP_EN
               else if (misaligned) state_next = RESP;
`else
               else if (misaligned) state_next = SPLIT;
`endif
               else                 state_next = BEAT;
            end
         end
         BEAT:    state_next = RESP;
         SPLIT:   if (last_beat) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      case (funct3_q)
         3'b000:  extended = {{24{data_q[7]}}, data_q[7:0]};
         3'b001:  extended = {{16{data_q[15]}}, data_q[15:0]};
         3'b100:  extended = {24'h0, data_q[7:0]};
         3'b101:  extended = {16'h0, data_q[15:0]};
         default: extended = data_q;
      endcase
   end

   always_comb begin
      req_ready      = (state == IDLE);
      busy           = (state != IDLE);
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = 32'h0;
      mem_load_code  = 3'b111;
      mem_store_code = 2'b11;
      case (state)
         BEAT: begin
            if (we_q) mem_store_code = funct3_q[1:0];
            else      mem_load_code  = funct3_q;
         end
         SPLIT: begin
            if (we_q) mem_store_code = 2'b00;
            else      mem_load_code  = 3'b100;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (we_q || err_q) ? 32'h0 : extended;
         end
         default: ;
      endcase
   end

   // mem_addr/mem_wdata are loaded one edge ahead so they are stable for the whole beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         data_q    <= 32'h0;
         err_q     <= 1'b0;
         k         <= 2'd0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  data_q   <= 32'h0;
                  k        <= 2'd0;
                  err_q    <= (state_next == RESP);
                  if (state_next == BEAT) begin
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                  end else if (state_next == SPLIT) begin
                     mem_addr  <= req_addr;
                     mem_wdata <= {24'h0, req_wdata[7:0]};
                  end
               end
            end
            BEAT: begin
               if (!we_q) data_q <= mem_rdata;
            end
            SPLIT: begin
               if (!we_q) data_q[8*k +: 8] <= mem_rdata[7:0];
               k <= k_next;
               if (!last_beat) begin
                  mem_addr  <= addr_plus;
                  mem_wdata <= {24'h0, wdata_q[8*k_next +: 8]};
               end
            end
            default: ;
         endcase
      end
   end
endmodule
